// File: rtl/accum_feeder_if.sv
// Load/run/accumulator bundle between an upstream master and accum_feeder.
// The master drives buffer writes and run requests; the feeder drives status and accumulator operands.
interface accum_feeder_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned DEPTH      = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                         wr_en;
  logic [AW-1:0]                wr_addr;
  logic signed [DATA_WIDTH-1:0] wr_data;
  logic [AW:0]                  len;
  logic                         start;
  logic                         busy;
  logic                         done;
  logic                         err;
  logic                         wr_drop;
  logic                         acc_clr_n;
  logic                         acc_start;
  logic signed [DATA_WIDTH-1:0] acc_data;
  logic [7:0]                   acc_iters;

  modport master (
    output wr_en, wr_addr, wr_data, len, start,
    input  busy, done, err, wr_drop, acc_clr_n, acc_start, acc_data, acc_iters
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, start,
    output busy, done, err, wr_drop, acc_clr_n, acc_start, acc_data, acc_iters
  );
endinterface

// File: rtl/accum_feeder.sv
// Operand sequencer for an Accumulator: buffers up to DEPTH signed samples, then clears the
// accumulator and streams the samples into it, one per cycle, pulsing done when the sum is final.
module accum_feeder #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned DEPTH      = 8
) (
  input logic           clk,
  input logic           rstn,
  accum_feeder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  // The accumulator result is DATA_WIDTH+3 bits, so more than 8 full-scale samples could overflow it.
  if (DEPTH > 8 || DEPTH < 2) begin : g_depth_chk
    $error("accum_feeder: DEPTH must be within 2..8");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                       state_q, state_d;
  logic [AW-1:0]                idx_q, idx_d;
  logic [LW-1:0]                len_q, len_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;
  logic                         drop_q, drop_d;
  logic                         clr_n_q, clr_n_d;
  logic                         start_q, start_d;
  logic signed [DATA_WIDTH-1:0] data_q, data_d;
  logic [7:0]                   iters_q, iters_d;
  logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                         len_ok;
  logic                         wr_ok;

  assign len_ok = (bus.len != '0) && (bus.len <= LW'(DEPTH));
  assign wr_ok  = bus.wr_en && (state_q == S_IDLE) && (LW'(bus.wr_addr) < LW'(DEPTH));

  // Sample buffer: written only while idle, contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      clr_n_q <= 1'b1;
      start_q <= 1'b0;
      data_q  <= '0;
      iters_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      clr_n_q <= clr_n_d;
      start_q <= start_d;
      data_q  <= data_d;
      iters_q <= iters_d;
    end
  end

  // Outputs register the behaviour of the current state, so they trail the state by one cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    busy_d  = (state_q != S_IDLE);
    done_d  = (state_q == S_DONE);
    err_d   = 1'b0;
    drop_d  = bus.wr_en && (state_q != S_IDLE);
    clr_n_d = 1'b1;
    start_d = 1'b0;
    data_d  = '0;
    iters_d = iters_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (len_ok) begin
            len_d   = bus.len;
            idx_d   = '0;
            state_d = S_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        clr_n_d = 1'b0;
        iters_d = 8'(len_q - LW'(1));
        state_d = S_STREAM;
      end
      S_STREAM: begin
        start_d = 1'b1;
        data_d  = mem_q[idx_q];
        idx_d   = idx_q + AW'(1);
        if (LW'(idx_q) == len_q - LW'(1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        start_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.wr_drop   = drop_q;
  assign bus.acc_clr_n = clr_n_q;
  assign bus.acc_start = start_q;
  assign bus.acc_data  = data_q;
  assign bus.acc_iters = iters_q;
endmodule

// File: tb/tb_accum_feeder.sv
// Bench for accum_feeder: a sample-buffer model plus a behavioural accumulator (sum of streamed
// operands since the last clear) checked against expected run results and handshake timing.
module tb_accum_feeder;
  localparam int unsigned DW    = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned LW    = AW + 1;

  logic clk = 1'b0;
  logic rstn;
  int   errors = 0;
  int   checks = 0;
  int   ref_mem [DEPTH];

  accum_feeder_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();
  accum_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.len = '0; bus.start = 1'b0;
  endtask

  task automatic write_mem(input int a, input int d);
    bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_data = DW'(d);
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    ref_mem[a] = d;
  endtask

  function automatic int exp_sum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += ref_mem[i];
    return s;
  endfunction

  // Runs one sequence and reports what a downstream accumulator would have seen.
  task automatic do_run(input int n, input int inject, input bit sim_wr, input int sim_a,
                        input int sim_d, output int done_cyc, output int sum, output int nstream,
                        output int iters, output bit busy1, output bit busy_end,
                        output bit drop_seen, output bit err_seen);
    bus.len = LW'(n); bus.start = 1'b1;
    if (sim_wr) begin bus.wr_en = 1'b1; bus.wr_addr = AW'(sim_a); bus.wr_data = DW'(sim_d); end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.wr_en = 1'b0;
    if (sim_wr) ref_mem[sim_a] = sim_d;
    done_cyc = -1; sum = 0; nstream = 0; iters = -1;
    busy1 = 1'b0; busy_end = 1'b1; drop_seen = 1'b0; err_seen = 1'b0;
    for (int k = 1; k <= n + 12; k++) begin
      if (k == inject) begin
        bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = DW'($urandom); bus.start = 1'b1; bus.len = '0;
      end
      @(posedge clk); #1;
      if (k == inject) begin bus.wr_en = 1'b0; bus.start = 1'b0; end
      if (k == 1) busy1 = bus.busy;
      if (!bus.acc_clr_n) begin sum = 0; nstream = 0; end
      if (bus.acc_start) begin sum += int'($signed(bus.acc_data)); nstream++; end
      if (bus.wr_drop) drop_seen = 1'b1;
      if (bus.err) err_seen = 1'b1;
      if (bus.done) begin done_cyc = k; iters = int'(bus.acc_iters); break; end
    end
    @(posedge clk); #1;
    busy_end = bus.busy;
  endtask

  task automatic test_reset();
    rstn = 1'b0; idle_inputs();
    repeat (2) @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", bus.err); end
    checks++; if (bus.wr_drop !== 1'b0) begin errors++; $display("FAIL reset_wr_drop: got %0b want 0", bus.wr_drop); end
    checks++; if (bus.acc_clr_n !== 1'b1) begin errors++; $display("FAIL reset_clr_n: got %0b want 1", bus.acc_clr_n); end
    checks++; if (bus.acc_start !== 1'b0) begin errors++; $display("FAIL reset_acc_start: got %0b want 0", bus.acc_start); end
    checks++; if (bus.acc_data !== '0) begin errors++; $display("FAIL reset_acc_data: got %0d want 0", bus.acc_data); end
    checks++; if (bus.acc_iters !== 8'd0) begin errors++; $display("FAIL reset_acc_iters: got %0d want 0", bus.acc_iters); end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int dc, s, ns, it; bit b1, be, ds, es;
    write_mem(0, 1); write_mem(1, 2); write_mem(2, 3); write_mem(3, -1);
    do_run(4, 0, 1'b0, 0, 0, dc, s, ns, it, b1, be, ds, es);
    checks++; if (dc != 7) begin errors++; $display("FAIL basic_done_cycle: got %0d want 7", dc); end
    checks++; if (s != 5) begin errors++; $display("FAIL basic_sum: got %0d want 5", s); end
    checks++; if (ns != 5) begin errors++; $display("FAIL basic_start_cycles: got %0d want 5", ns); end
    checks++; if (it != 3) begin errors++; $display("FAIL basic_iters: got %0d want 3", it); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b want 1", b1); end
    checks++; if (be !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %0b want 0", be); end
  endtask

  task automatic test_back_to_back();
    int dc, s, ns, it; bit b1, be, ds, es;
    write_mem(0, 7); write_mem(1, 7);
    do_run(2, 0, 1'b0, 0, 0, dc, s, ns, it, b1, be, ds, es);
    checks++; if (dc != 5) begin errors++; $display("FAIL b2b_done_cycle: got %0d want 5", dc); end
    checks++; if (s != 14) begin errors++; $display("FAIL b2b_sum: got %0d want 14", s); end
    checks++; if (it != 1) begin errors++; $display("FAIL b2b_iters: got %0d want 1", it); end
  endtask

  task automatic test_illegal_len();
    int bad [2] = '{0, 9};
    for (int i = 0; i < 2; i++) begin
      bus.len = LW'(bad[i]); bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL illegal_err len=%0d: got %0b want 1", bad[i], bus.err); end
      checks++; if (bus.acc_iters !== 8'd1) begin errors++; $display("FAIL illegal_iters len=%0d: got %0d want 1", bad[i], bus.acc_iters); end
      checks++; if (bus.acc_clr_n !== 1'b1 || bus.acc_start !== 1'b0) begin errors++; $display("FAIL illegal_acc len=%0d: clr_n=%0b start=%0b want 1/0", bad[i], bus.acc_clr_n, bus.acc_start); end
      @(posedge clk); #1;
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL illegal_err_pulse len=%0d: got %0b want 0", bad[i], bus.err); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL illegal_busy len=%0d: got %0b want 0", bad[i], bus.busy); end
    end
  endtask

  task automatic test_busy_writes();
    int dc, s, ns, it; bit b1, be, ds, es;
    write_mem(0, 1); write_mem(1, 2); write_mem(2, 3); write_mem(3, -1);
    do_run(4, 3, 1'b0, 0, 0, dc, s, ns, it, b1, be, ds, es);
    checks++; if (ds !== 1'b1) begin errors++; $display("FAIL busy_wr_drop: got %0b want 1", ds); end
    checks++; if (es !== 1'b0) begin errors++; $display("FAIL busy_start_err: got %0b want 0", es); end
    checks++; if (s != 5) begin errors++; $display("FAIL busy_sum: got %0d want 5", s); end
    checks++; if (dc != 7) begin errors++; $display("FAIL busy_done_cycle: got %0d want 7", dc); end
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_no_queue: got %0b want 0", bus.busy); end
    do_run(4, 0, 1'b0, 0, 0, dc, s, ns, it, b1, be, ds, es);
    checks++; if (s != 5) begin errors++; $display("FAIL busy_buf_kept: got %0d want 5", s); end
  endtask

  task automatic test_full_scale();
    int dc, s, ns, it; bit b1, be, ds, es;
    int vals [2] = '{-8, 7};
    int want [2] = '{-64, 56};
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < 8; i++) write_mem(i, vals[v]);
      do_run(8, 0, 1'b0, 0, 0, dc, s, ns, it, b1, be, ds, es);
      checks++; if (s != want[v]) begin errors++; $display("FAIL full_scale_sum: got %0d want %0d", s, want[v]); end
      checks++; if (dc != 11 || it != 7) begin errors++; $display("FAIL full_scale_timing: done=%0d iters=%0d want 11/7", dc, it); end
    end
  endtask

  task automatic test_random();
    int dc, s, ns, it, n, sa, sd; bit b1, be, ds, es, sw;
    for (int i = 0; i < 8; i++) write_mem(i, int'($urandom_range(0, 15)) - 8);
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 1) == 1) write_mem(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)) - 8);
      n  = int'($urandom_range(1, 8));
      sw = 1'($urandom_range(0, 1));
      sa = int'($urandom_range(0, n - 1));
      sd = int'($urandom_range(0, 15)) - 8;
      do_run(n, 0, sw, sa, sd, dc, s, ns, it, b1, be, ds, es);
      checks++; if (s != exp_sum(n)) begin errors++; $display("FAIL random_sum run=%0d len=%0d: got %0d want %0d", r, n, s, exp_sum(n)); end
      checks++; if (dc != n + 3 || it != n - 1 || ns != n + 1) begin errors++; $display("FAIL random_timing run=%0d len=%0d: done=%0d iters=%0d starts=%0d want %0d/%0d/%0d", r, n, dc, it, ns, n + 3, n - 1, n + 1); end
    end
  endtask

  task automatic test_reset_midrun();
    int dc, s, ns, it; bit b1, be, ds, es;
    for (int i = 0; i < 8; i++) write_mem(i, i - 3);
    bus.len = LW'(8); bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midrst_status: busy=%0b done=%0b want 0/0", bus.busy, bus.done); end
    checks++; if (bus.acc_start !== 1'b0 || bus.acc_clr_n !== 1'b1) begin errors++; $display("FAIL midrst_acc_ctl: start=%0b clr_n=%0b want 0/1", bus.acc_start, bus.acc_clr_n); end
    checks++; if (bus.acc_data !== '0 || bus.acc_iters !== 8'd0) begin errors++; $display("FAIL midrst_acc_val: data=%0d iters=%0d want 0/0", bus.acc_data, bus.acc_iters); end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    do_run(3, 0, 1'b0, 0, 0, dc, s, ns, it, b1, be, ds, es);
    checks++; if (s != exp_sum(3)) begin errors++; $display("FAIL midrst_rerun_sum: got %0d want %0d", s, exp_sum(3)); end
    checks++; if (dc != 6 || it != 2) begin errors++; $display("FAIL midrst_rerun_timing: done=%0d iters=%0d want 6/2", dc, it); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_illegal_len();
    test_busy_writes();
    test_full_scale();
    test_random();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
